thr_cfg_ctrl: RTL and testbench

//  Run-time configurator for the RGB565 colour-threshold stage. Three push-keys select one of six

---
 rtl/thr_cfg_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_thr_cfg_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/thr_cfg_ctrl.sv
// Push-key configurator for the RGB565 threshold limits: debounced keys edit shadow
// limits, which are copied to the active outputs only at the rising edge of vsync.
module thr_cfg_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_CYC   = 5000000,
  parameter int R_MIN_INIT   = 0,
  parameter int R_MAX_INIT   = 8,
  parameter int G_MIN_INIT   = 0,
  parameter int G_MAX_INIT   = 16,
  parameter int B_MIN_INIT   = 0,
  parameter int B_MAX_INIT   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_sel_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic       in_vs,
  output logic [4:0] red_min,
  output logic [4:0] red_max,
  output logic [5:0] green_min,
  output logic [5:0] green_max,
  output logic [4:0] blue_min,
  output logic [4:0] blue_max,
  output logic [2:0] sel_idx,
  output logic       pending
);

  localparam int DBW     = $clog2(DEBOUNCE_CYC + 1);
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
  localparam int RPW     = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  logic [2:0]     w_key_raw;
  logic [2:0]     r_key_s1;
  logic [2:0]     r_key_s2;
  logic           r_vs_s1;
  logic           r_vs_s2;
  logic           r_vs_s3;
  logic [2:0]     r_deb;
  logic [2:0]     r_press;
  logic [DBW-1:0] r_deb_cnt [3];

  state_t         r_state;
  state_t         w_state_nx;
  logic [1:0]     r_key;
  logic [1:0]     w_key_nx;
  logic [RPW-1:0] r_rpt_cnt;
  logic [RPW-1:0] w_rpt_nx;
  logic           w_rel;
  logic           w_do_sel;
  logic           w_do_up;
  logic           w_do_dn;

  logic [5:0]     r_shadow [6];
  logic [2:0]     r_sel;
  logic           r_pending;
  logic [5:0]     w_cur;
  logic [5:0]     w_pair;
  logic [5:0]     w_lim;
  logic [5:0]     w_next_val;
  logic           w_up_ok;
  logic           w_dn_ok;
  logic           w_step;
  logic           w_commit;

  assign w_key_raw = {key_dn_n, key_up_n, key_sel_n};

  // Synchronisers reset to the "pressed" level so a key held through reset is never seen as a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_s1 <= 3'b000;
      r_key_s2 <= 3'b000;
      r_vs_s1  <= 1'b0;
      r_vs_s2  <= 1'b0;
      r_vs_s3  <= 1'b0;
    end else begin
      r_key_s1 <= w_key_raw;
      r_key_s2 <= r_key_s1;
      r_vs_s1  <= in_vs;
      r_vs_s2  <= r_vs_s1;
      r_vs_s3  <= r_vs_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb   <= 3'b000;
      r_press <= 3'b000;
      for (int k = 0; k < 3; k++) r_deb_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        r_press[k] <= 1'b0;
        if (r_key_s2[k] == r_deb[k]) begin
          r_deb_cnt[k] <= '0;
        end else if (r_deb_cnt[k] == DBW'(DEBOUNCE_CYC - 1)) begin
          r_deb[k]     <= r_key_s2[k];
          r_deb_cnt[k] <= '0;
          r_press[k]   <= ~r_key_s2[k];
        end else begin
          r_deb_cnt[k] <= r_deb_cnt[k] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_key     <= 2'd0;
      r_rpt_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_key     <= w_key_nx;
      r_rpt_cnt <= w_rpt_nx;
    end
  end

  assign w_rel = r_deb[r_key];

  // Key index: 0 sel, 1 up, 2 dn. Only the key that started a hold can end it.
  always_comb begin
    w_state_nx = r_state;
    w_key_nx   = r_key;
    w_rpt_nx   = r_rpt_cnt;
    w_do_sel   = 1'b0;
    w_do_up    = 1'b0;
    w_do_dn    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rpt_nx = '0;
        if (r_press[0]) begin
          w_do_sel   = 1'b1;
          w_key_nx   = 2'd0;
          w_state_nx = ST_HOLD;
        end else if (r_press[1]) begin
          w_do_up    = 1'b1;
          w_key_nx   = 2'd1;
          w_state_nx = ST_HOLD;
        end else if (r_press[2]) begin
          w_do_dn    = 1'b1;
          w_key_nx   = 2'd2;
          w_state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_rel) begin
          w_state_nx = ST_IDLE;
          w_rpt_nx   = '0;
        end else if (r_key != 2'd0) begin
          if (r_rpt_cnt == RPW'(REPEAT_DLY - 1)) begin
            w_state_nx = ST_REPEAT;
            w_rpt_nx   = '0;
          end else begin
            w_rpt_nx = r_rpt_cnt + RPW'(1);
          end
        end
      end
      ST_REPEAT: begin
        if (w_rel) begin
          w_state_nx = ST_IDLE;
          w_rpt_nx   = '0;
        end else if (r_rpt_cnt == RPW'(REPEAT_CYC - 1)) begin
          w_do_up  = (r_key == 2'd1);
          w_do_dn  = (r_key == 2'd2);
          w_rpt_nx = '0;
        end else begin
          w_rpt_nx = r_rpt_cnt + RPW'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_rpt_nx   = '0;
      end
    endcase
  end

  // Even indices are mins, odd are maxes; each limit's partner is at index ^ 1.
  assign w_cur      = r_shadow[r_sel];
  assign w_pair     = r_shadow[r_sel ^ 3'd1];
  assign w_lim      = (r_sel == 3'd2 || r_sel == 3'd3) ? 6'd63 : 6'd31;
  assign w_up_ok    = r_sel[0] ? (w_cur < w_lim) : (w_cur < w_pair);
  assign w_dn_ok    = r_sel[0] ? (w_cur > w_pair) : (w_cur != 6'd0);
  assign w_step     = (w_do_up & w_up_ok) | (w_do_dn & w_dn_ok);
  assign w_next_val = w_do_up ? (w_cur + 6'd1) : (w_cur - 6'd1);
  assign w_commit   = r_vs_s2 & ~r_vs_s3 & r_pending;

  // Commit samples the shadow before any same-cycle step, so that step stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow[0] <= 6'(R_MIN_INIT);
      r_shadow[1] <= 6'(R_MAX_INIT);
      r_shadow[2] <= 6'(G_MIN_INIT);
      r_shadow[3] <= 6'(G_MAX_INIT);
      r_shadow[4] <= 6'(B_MIN_INIT);
      r_shadow[5] <= 6'(B_MAX_INIT);
      r_sel       <= 3'd0;
      r_pending   <= 1'b0;
      red_min     <= 5'(R_MIN_INIT);
      red_max     <= 5'(R_MAX_INIT);
      green_min   <= 6'(G_MIN_INIT);
      green_max   <= 6'(G_MAX_INIT);
      blue_min    <= 5'(B_MIN_INIT);
      blue_max    <= 5'(B_MAX_INIT);
    end else begin
      if (w_do_sel) begin
        r_sel <= (r_sel == 3'd5) ? 3'd0 : (r_sel + 3'd1);
      end
      if (w_step) begin
        r_shadow[r_sel] <= w_next_val;
      end
      if (w_commit) begin
        red_min   <= r_shadow[0][4:0];
        red_max   <= r_shadow[1][4:0];
        green_min <= r_shadow[2];
        green_max <= r_shadow[3];
        blue_min  <= r_shadow[4][4:0];
        blue_max  <= r_shadow[5][4:0];
      end
      if (w_step) begin
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign sel_idx = r_sel;
  assign pending = r_pending;

endmodule

// File: tb/tb_thr_cfg_ctrl.sv
// Directed and randomized bench for thr_cfg_ctrl, checked against a rule-level model
// of the shadow/active limits, selection and pending flag.
module tb_thr_cfg_ctrl;

  localparam int DB = 4;
  localparam int RD = 32;
  localparam int RC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_sel_n = 1'b1;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic       in_vs = 1'b0;
  logic [4:0] red_min;
  logic [4:0] red_max;
  logic [5:0] green_min;
  logic [5:0] green_max;
  logic [4:0] blue_min;
  logic [4:0] blue_max;
  logic [2:0] sel_idx;
  logic       pending;

  int checks = 0;
  int errors = 0;
  int shadowM [6];
  int activeM [6];
  int selM;
  bit pendM;

  thr_cfg_ctrl #(
    .DEBOUNCE_CYC(DB),
    .REPEAT_DLY(RD),
    .REPEAT_CYC(RC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_sel_n(key_sel_n),
    .key_up_n(key_up_n),
    .key_dn_n(key_dn_n),
    .in_vs(in_vs),
    .red_min(red_min),
    .red_max(red_max),
    .green_min(green_min),
    .green_max(green_max),
    .blue_min(blue_min),
    .blue_max(blue_max),
    .sel_idx(sel_idx),
    .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    shadowM = '{0, 8, 0, 16, 0, 8};
    activeM = shadowM;
    selM    = 0;
    pendM   = 1'b0;
  endfunction

  // One up/down step under the saturation and min<=max rules.
  function automatic void modelStep(input bit up);
    int lim;
    int nv;
    lim = (selM == 2 || selM == 3) ? 63 : 31;
    nv  = up ? shadowM[selM] + 1 : shadowM[selM] - 1;
    if (nv < 0 || nv > lim) return;
    if (selM % 2 == 0 && nv > shadowM[selM + 1]) return;
    if (selM % 2 == 1 && nv < shadowM[selM - 1]) return;
    shadowM[selM] = nv;
    pendM = 1'b1;
  endfunction

  // A hold of h cycles yields the initial step plus one step per full repeat period past the delay.
  function automatic void modelPress(input int k, input int h);
    int n;
    if (k == 0) begin
      selM = (selM + 1) % 6;
    end else begin
      n = 1 + ((h >= RD) ? (h - RD) / RC : 0);
      for (int i = 0; i < n; i++) modelStep(k == 1);
    end
  endfunction

  function automatic void modelCommit();
    if (pendM) begin
      activeM = shadowM;
      pendM = 1'b0;
    end
  endfunction

  task automatic setKey(input int k, input logic v);
    case (k)
      0: key_sel_n = v;
      1: key_up_n = v;
      default: key_dn_n = v;
    endcase
  endtask

  task automatic applyStimulus(input int k, input int h);
    @(posedge clk);
    #1 setKey(k, 1'b0);
    repeat (h) @(posedge clk);
    #1 setKey(k, 1'b1);
    repeat (14) @(posedge clk);
    modelPress(k, h);
  endtask

  task automatic pulseVsync();
    @(posedge clk);
    #1 in_vs = 1'b1;
    repeat (4) @(posedge clk);
    #1 in_vs = 1'b0;
    repeat (6) @(posedge clk);
    modelCommit();
  endtask

  task automatic checkOne(input string tag, input logic [31:0] got, input int want);
    checks++;
    assert (got === 32'(want))
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    @(negedge clk);
    checkOne({tag, ".rmin"}, 32'(red_min), activeM[0]);
    checkOne({tag, ".rmax"}, 32'(red_max), activeM[1]);
    checkOne({tag, ".gmin"}, 32'(green_min), activeM[2]);
    checkOne({tag, ".gmax"}, 32'(green_max), activeM[3]);
    checkOne({tag, ".bmin"}, 32'(blue_min), activeM[4]);
    checkOne({tag, ".bmax"}, 32'(blue_max), activeM[5]);
    checkOne({tag, ".sel"}, 32'(sel_idx), selM);
    checkOne({tag, ".pend"}, 32'(pending), int'(pendM));
  endtask

  initial begin
    int op;
    int k;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    checkOutput("reset");

    // Bouncy up key: short glitches must not register, the final hold gives one step.
    for (int g = 0; g < 3; g++) begin
      @(posedge clk);
      #1 key_up_n = 1'b0;
      repeat ($urandom_range(1, DB - 1)) @(posedge clk);
      #1 key_up_n = 1'b1;
      repeat ($urandom_range(1, DB - 1)) @(posedge clk);
    end
    #1 key_up_n = 1'b0;
    repeat (20) @(posedge clk);
    #1 key_up_n = 1'b1;
    repeat (14) @(posedge clk);
    modelPress(1, 20);
    checkOutput("bounce");
    pulseVsync();
    checkOutput("bounceCommit");

    for (int i = 0; i < 3; i++) applyStimulus(0, $urandom_range(6, 20));
    applyStimulus(1, RD + RC * 4 + 4);
    checkOutput("gmaxRepeat");
    pulseVsync();
    checkOutput("gmaxCommit");

    applyStimulus(0, RD + RC * 3 + 4);
    for (int i = 0; i < 3; i++) applyStimulus(0, $urandom_range(6, 20));
    for (int i = 0; i < 9; i++) applyStimulus(2, $urandom_range(6, 20));
    checkOutput("rmaxFloor");
    pulseVsync();
    applyStimulus(2, 10);
    checkOutput("rmaxBlocked");

    applyStimulus(0, 10);
    applyStimulus(0, 10);
    applyStimulus(1, RD + RC * 45 + 4);
    pulseVsync();
    applyStimulus(1, 10);
    checkOutput("gmaxSat");
    for (int i = 0; i < 6; i++) applyStimulus(0, $urandom_range(6, 20));
    checkOutput("selWrap");

    // Down-step pulse lands on the same edge as the vsync commit.
    applyStimulus(2, 10);
    @(posedge clk);
    #1 key_dn_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 in_vs = 1'b1;
    repeat (4) @(posedge clk);
    #1 in_vs = 1'b0;
    repeat (8) @(posedge clk);
    #1 key_dn_n = 1'b1;
    repeat (14) @(posedge clk);
    modelCommit();
    modelPress(2, 16);
    checkOutput("coincide");
    pulseVsync();
    checkOutput("coincideNext");

    // Reset while a key is held: no action until it is released and pressed again.
    @(posedge clk);
    #1 key_up_n = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    checkOutput("rstHold");
    #1 key_up_n = 1'b1;
    repeat (14) @(posedge clk);
    checkOutput("rstRelease");
    applyStimulus(1, 10);
    checkOutput("rstRepress");

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: applyStimulus(0, $urandom_range(6, 60));
        2: applyStimulus(1, $urandom_range(6, 24));
        3: applyStimulus(2, $urandom_range(6, 24));
        4: begin
          k = $urandom_range(1, 2);
          applyStimulus(k, RD + RC * $urandom_range(0, 3) + 4);
        end
        default: pulseVsync();
      endcase
      checkOutput($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
